// File: rtl/mpi_pkg.sv
// Shared definitions for the MPI register bridge: FSM state encoding and
// default parameter values used by the bridge top level.
package mpi_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DEPTH  = 48;
    localparam int DEF_ERR_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/mpi_sync.sv
// Parametrised-width 2-flop synchroniser for bringing asynchronous host
// signals into the clk domain.
//   clk   : system clock
//   rst_n : asynchronous active-low reset, flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronised output (2 clock edges of latency)
module mpi_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mpi_reg_bridge.sv
// Asynchronous microprocessor-interface to register-file bridge.
// The host strobes Mpi_cs_n low with address, direction and data held
// stable; the bridge synchronises everything, performs one register read
// or write per cs_n low period and signals completion on Mpi_rdy_n.
//   Clock     : system clock
//   Rst_n     : asynchronous active-low reset
//   Mpi_data  : bidirectional host data bus, driven only for reads in HOLD
//   Mpi_addr  : host address (async)
//   Mpi_cs_n  : host chip select, active-low (async)
//   Mpi_rw    : 1 = read, 0 = write (async)
//   Mpi_rdy_n : access complete, active-low
//   Wr_pulse  : one-cycle strobe on an in-range write commit
//   Wr_addr   : address of the last committed write
//   Err_cnt   : saturating count of out-of-range accesses
//
// state | meaning
// IDLE  | waiting for a synchronised falling edge of cs_n
// WRITE | one cycle, commits data to the addressed register
// READ  | one cycle, loads the addressed register into rd_q
// HOLD  | access done, waits for synchronised cs_n to return high
module mpi_reg_bridge
    import mpi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic              Clock,
    input  logic              Rst_n,
    inout  wire  [DATA_W-1:0] Mpi_data,
    input  logic [ADDR_W-1:0] Mpi_addr,
    input  logic              Mpi_cs_n,
    input  logic              Mpi_rw,
    output logic              Mpi_rdy_n,
    output logic              Wr_pulse,
    output logic [ADDR_W-1:0] Wr_addr,
    output logic [ERR_W-1:0]  Err_cnt
);

    state_t state, state_next;

    logic [1:0]        ctl_s;
    logic              cs_s;
    logic              rw_s;
    logic              cs_d;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;
    logic              start;
    logic              in_range;

    logic [ADDR_W-1:0] acc_addr;
    logic              acc_ok;
    logic              acc_rd;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              hold_sel;

    // cs_n resets to the asserted level so a select held low through
    // reset release cannot look like a fresh falling edge.
    mpi_sync #(.WIDTH(2), .RST_VAL(2'b00)) u_sync_ctl (
        .clk   (Clock),
        .rst_n (Rst_n),
        .d     ({Mpi_cs_n, Mpi_rw}),
        .q     (ctl_s)
    );

    mpi_sync #(.WIDTH(ADDR_W)) u_sync_addr (
        .clk   (Clock),
        .rst_n (Rst_n),
        .d     (Mpi_addr),
        .q     (addr_s)
    );

    mpi_sync #(.WIDTH(DATA_W)) u_sync_data (
        .clk   (Clock),
        .rst_n (Rst_n),
        .d     (Mpi_data),
        .q     (data_s)
    );

    assign cs_s     = ctl_s[1];
    assign rw_s     = ctl_s[0];
    assign start    = cs_d & ~cs_s;
    assign in_range = int'(addr_s) < DEPTH;

    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            cs_d  <= 1'b0;
            state <= IDLE;
        end else begin
            cs_d  <= cs_s;
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = rw_s ? READ : WRITE;
            WRITE: state_next = HOLD;
            READ:  state_next = HOLD;
            HOLD:  if (cs_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Access attributes are captured at the start so that address or
    // direction changes during HOLD cannot influence the access.
    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            acc_addr <= '0;
            acc_ok   <= 1'b0;
            acc_rd   <= 1'b0;
            Wr_addr  <= '0;
            rd_q     <= '0;
            Err_cnt  <= '0;
        end else begin
            if (state == IDLE && start) begin
                acc_addr <= addr_s;
                acc_ok   <= in_range;
                acc_rd   <= rw_s;
                if (!rw_s && in_range) Wr_addr <= addr_s;
            end
            if (state == READ) rd_q <= acc_ok ? regs[acc_addr] : '0;
            if ((state == WRITE || state == READ) && !acc_ok && Err_cnt != '1)
                Err_cnt <= Err_cnt + ERR_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (state == WRITE && acc_ok) begin
            regs[acc_addr] <= data_s;
        end
    end

    assign Wr_pulse = (state == WRITE) && acc_ok;

    // Raw cs_n gates the bus and ready so both release the instant the
    // host deasserts select, without waiting for the synchroniser.
    assign hold_sel  = (state == HOLD) && !Mpi_cs_n;
    assign Mpi_rdy_n = !hold_sel;
    assign Mpi_data  = (hold_sel && acc_rd) ? rd_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mpi_reg_bridge.sv
// Scoreboard bench for mpi_reg_bridge. The host tasks push expected read
// data and write addresses into queues; a monitor on the falling clock edge
// pops and compares whenever ready falls or Wr_pulse is seen. The bus has
// pullups so a released bus reads as all ones.
module tb_mpi_reg_bridge;

    logic       clk = 1'b0;
    logic       rst_n;
    wire  [7:0] mpi_data;
    logic [5:0] h_addr;
    logic       h_cs_n;
    logic       h_rw;
    logic       h_drv;
    logic [7:0] h_dat;
    logic       rdy_n;
    logic       wr_pulse;
    logic [5:0] wr_addr;
    logic [1:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rd_exp [$];
    logic [5:0] wr_exp [$];
    logic [7:0] mem [48];

    localparam logic [7:0] BUS_Z = 8'hFF;

    always #5 clk = ~clk;

    assign mpi_data = h_drv ? h_dat : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (mpi_data[i]);
    end

    mpi_reg_bridge #(.DATA_W(8), .ADDR_W(6), .DEPTH(48), .ERR_W(2)) dut (
        .Clock     (clk),
        .Rst_n     (rst_n),
        .Mpi_data  (mpi_data),
        .Mpi_addr  (h_addr),
        .Mpi_cs_n  (h_cs_n),
        .Mpi_rw    (h_rw),
        .Mpi_rdy_n (rdy_n),
        .Wr_pulse  (wr_pulse),
        .Wr_addr   (wr_addr),
        .Err_cnt   (err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor
    logic rdy_prev = 1'b1;
    logic wp_prev  = 1'b0;
    always @(negedge clk) begin
        if (!rdy_n && rdy_prev) begin
            if (h_rw) begin
                if (rd_exp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_read: bus %0h, no read expected", mpi_data);
                end else begin
                    chk("read_data", mpi_data, rd_exp.pop_front());
                end
            end else begin
                chk("write_bus_host_only", mpi_data, h_dat);
            end
        end
        if (wr_pulse && !wp_prev) begin
            if (wr_exp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_wr_pulse: wr_addr %0d, no write expected", wr_addr);
            end else begin
                chk("wr_addr", wr_addr, wr_exp.pop_front());
            end
        end
        if (wr_pulse && wp_prev) begin
            n_tests++;
            n_fail++;
            $display("FAIL wr_pulse_width: high for more than one cycle, got 1 expected 0");
        end
        rdy_prev = rdy_n;
        wp_prev  = wr_pulse;
    end

    task automatic wait_rdy(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (rdy_n && edges < 12);
        chk("rdy_latency", edges, 4);
    endtask

    task automatic access(input logic [5:0] a, input logic rw, input logic [7:0] d);
        int edges;
        @(posedge clk);
        #3;
        h_addr = a;
        h_rw   = rw;
        h_dat  = d;
        h_drv  = !rw;
        repeat (4) @(posedge clk);
        #3;
        h_cs_n = 1'b0;
        wait_rdy(edges);
        #23;
        h_cs_n = 1'b1;
        h_drv  = 1'b0;
        #1;
        chk("bus_z_after_cs", mpi_data, BUS_Z);
        chk("rdy_n_after_cs", rdy_n, 1'b1);
        repeat (4) @(posedge clk);
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        if (a < 48) begin
            wr_exp.push_back(a);
            mem[a] = d;
        end
        access(a, 1'b0, d);
    endtask

    task automatic rd(input logic [5:0] a);
        rd_exp.push_back((a < 48) ? mem[a] : 8'h00);
        access(a, 1'b1, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        rst_n  = 1'b0;
        h_cs_n = 1'b1;
        h_rw   = 1'b1;
        h_drv  = 1'b0;
        h_addr = '0;
        h_dat  = '0;
        foreach (mem[i]) mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        #3;
        chk("rst_rdy_n", rdy_n, 1'b1);
        chk("rst_wr_pulse", wr_pulse, 1'b0);
        chk("rst_wr_addr", wr_addr, 6'd0);
        chk("rst_err_cnt", err_cnt, 2'd0);
        chk("rst_bus_z", mpi_data, BUS_Z);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // top address write then read back
        wr(6'd47, 8'hA5);
        rd(6'd47);
        chk("wr_addr_hold", wr_addr, 6'd47);

        // full sweep, descending writes then ascending reads
        for (int a = 47; a >= 0; a--) wr(6'(a), 8'($urandom_range(0, 254)));
        for (int a = 0; a < 48; a++) rd(6'(a));
        chk("err_after_sweep", err_cnt, 2'd0);
        chk("wr_addr_after_sweep", wr_addr, 6'd0);

        // out-of-range accesses, counter saturates at 3 with ERR_W = 2
        wr(6'd50, 8'h3C);
        chk("err_after_oor_wr", err_cnt, 2'd1);
        rd(6'd50);
        chk("err_after_oor_rd", err_cnt, 2'd2);
        chk("wr_addr_unchanged", wr_addr, 6'd0);
        wr(6'd55, 8'h11);
        chk("err_third", err_cnt, 2'd3);
        rd(6'd63);
        wr(6'd48, 8'h22);
        chk("err_saturated", err_cnt, 2'd3);
        rd(6'd1);

        // short cs_n glitch between clock edges is ignored
        @(posedge clk);
        #3;
        h_addr = 6'd3;
        h_rw   = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        h_cs_n = 1'b0;
        #4;
        h_cs_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("glitch_rdy_n", rdy_n, 1'b1);
            chk("glitch_bus_z", mpi_data, BUS_Z);
        end

        // reset during HOLD of a read with cs_n held low
        rd_exp.push_back(mem[5]);
        @(posedge clk);
        #3;
        h_addr = 6'd5;
        h_rw   = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        h_cs_n = 1'b0;
        wait_rdy(edges);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_bus_z", mpi_data, BUS_Z);
        chk("rst_mid_rdy_n", rdy_n, 1'b1);
        chk("rst_mid_wr_addr", wr_addr, 6'd0);
        foreach (mem[i]) mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("cs_low_after_rst", rdy_n, 1'b1);
        end
        h_cs_n = 1'b1;
        repeat (4) @(posedge clk);
        rd(6'd5);
        chk("err_after_rst", err_cnt, 2'd0);

        repeat (4) @(posedge clk);
        chk("rd_queue_drained", rd_exp.size(), 0);
        chk("wr_queue_drained", wr_exp.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mpi_reg_bridge.md
MPI_REG_BRIDGE -- requirements
Module: mpi_reg_bridge

Interface
REQ-001 Parameter DATA_W, default 8: width of Mpi_data and of each register.
REQ-002 Parameter ADDR_W, default 6: width of Mpi_addr.
REQ-003 Parameter DEPTH, default 48: number of implemented registers, addresses 0..DEPTH-1, with DEPTH <= 2**ADDR_W.
REQ-004 Parameter ERR_W, default 8: width of the error counter.
REQ-005 Clock  input  1  single system clock; all logic on rising edge.
REQ-006 Rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Mpi_data  inout  DATA_W  bidirectional host data bus; high-Z unless the block is driving a read.
REQ-008 Mpi_addr  input  ADDR_W  host address, asynchronous to Clock.
REQ-009 Mpi_cs_n  input  1  host chip select, active-low, asynchronous.
REQ-010 Mpi_rw  input  1  1 = read, 0 = write; asynchronous.
REQ-011 Mpi_rdy_n  output  1  access-complete indication, active-low.
REQ-012 Wr_pulse  output  1  one-cycle pulse when an in-range write commits.
REQ-013 Wr_addr  output  ADDR_W  address of the last committed write.
REQ-014 Err_cnt  output  ERR_W  count of out-of-range accesses, saturating.

Function
REQ-015 Mpi_cs_n, Mpi_rw, Mpi_addr and Mpi_data SHALL each pass through a 2-flop synchroniser before use.
REQ-016 An access SHALL start only on a synchronised high-to-low transition of cs_n, detected with a third flop.
REQ-017 The start point SHALL be the cycle the edge is seen, 3 Clock edges after the raw cs_n falls. The host holds addr, rw and data stable at least 3 Clock periods before cs_n falls and throughout the access.
REQ-018 FSM states and transitions:
  - IDLE: waits for a start.
  - On start, IDLE -> WRITE if rw_s = 0, IDLE -> READ if rw_s = 1.
  - WRITE -> HOLD after 1 cycle; commits reg[addr_s] <= data_s if addr_s < DEPTH.
  - READ -> HOLD after 1 cycle; loads rd_q <= reg[addr_s], or all-zero if addr_s >= DEPTH.
  - HOLD -> IDLE when synchronised cs_n = 1.
REQ-019 Wr_pulse SHALL be high for exactly the WRITE cycle of an in-range write; Wr_addr SHALL update in the same cycle and then hold.
REQ-020 Mpi_data SHALL be driven with rd_q only when state = HOLD, the access is a read, and raw Mpi_cs_n = 0; it SHALL go high-Z combinationally when raw cs_n rises.
REQ-021 Mpi_rdy_n SHALL be 0 only when state = HOLD and raw Mpi_cs_n = 0, i.e. first low 4 cycles after raw cs_n falls.
REQ-022 An out-of-range access (addr_s >= DEPTH) SHALL leave registers unchanged and produce no Wr_pulse. It SHALL still complete the handshake, with reads returning 0.
REQ-023 Each out-of-range access SHALL increment Err_cnt by 1, saturating at 2**ERR_W-1.
REQ-024 A cs_n pulse too short to reach the synchroniser output SHALL be ignored. Once started, an access SHALL always finish, even if cs_n rises during WRITE or READ.
REQ-025 Changes to rw or addr while in HOLD SHALL have no effect. There is only one access per cs_n low period.

Reset
REQ-026 When Rst_n is low, the block SHALL immediately enter IDLE with all registers, rd_q, Wr_addr and Err_cnt at 0, Wr_pulse = 0, Mpi_rdy_n = 1 and Mpi_data high-Z.
REQ-027 The cs_n synchroniser and edge flops SHALL reset to 0 (asserted), so that a cs_n held low through reset release starts no access until it goes high and falls again.
REQ-028 Reset asserted mid-access SHALL abort the access: no partial commit, bus released in the same instant.

Structure
REQ-029 Shared package mpi_pkg SHALL hold the FSM state enum (IDLE, WRITE, READ, HOLD) and the default parameter constants.
REQ-030 One sub-module, mpi_sync (parametrised-width 2-flop synchroniser), SHALL be instantiated for the control, address and data inputs.

Verification (10 ns clock, host phase 24 ns)
REQ-031 Write 8'hA5 to addr 47, then read addr 47: Mpi_data = 8'hA5 when cs_n rises; Wr_pulse is one cycle with Wr_addr = 47.
REQ-032 Write 0..47 with random data in descending order, then read all back: every read matches; Err_cnt = 0.
REQ-033 Write to addr 50, then read addr 50: no Wr_pulse, read returns 0, Err_cnt = 2; with ERR_W = 2, after 5 such accesses Err_cnt = 3.
REQ-034 Pulse cs_n low for 4 ns: no FSM activity, Mpi_rdy_n stays 1, bus stays Z.
REQ-035 Assert Rst_n during HOLD of a read with cs_n held low: bus goes Z immediately, and no access occurs after reset release until cs_n toggles high then low.
REQ-036 Check Mpi_data is Z whenever cs_n = 1 or rw = 0, and that Mpi_rdy_n falls exactly 4 clock edges after cs_n falls.
